// File: rtl/mul_share_arbiter.sv
// Shares one multi-cycle multiplier between two requesters: round-robin grant,
// operand latch, start/done handshake with a watchdog abort, per-requester response.
module mul_share_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [2*WIDTH-1:0]   rsp0_data,
    output logic                 rsp0_err,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp1_data,
    output logic                 rsp1_err,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_result,
    output logic                 mul_abort
);
    localparam int unsigned PW       = 2 * WIDTH;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    state_t           r_state;
    logic             r_gnt;
    logic             r_last_gnt;
    logic [7:0]       r_timer;
    logic [PW-1:0]    r_res_q;
    logic             r_err_q;
    logic             r_mul_start;
    logic             r_mul_abort;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;
    logic [1:0]       r_rsp_valid;

    logic             w_sel;
    logic             w_accept;
    logic             w_rsp_fire;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    // On a tie the requester that did not own the last completed operation wins.
    always_comb begin
        w_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            w_sel = ~r_last_gnt;
        end else if (req1_valid) begin
            w_sel = 1'b1;
        end
    end

    assign w_accept   = rst_n && (r_state == ST_IDLE) && (req0_valid || req1_valid);
    assign w_sel_a    = w_sel ? req1_a : req0_a;
    assign w_sel_b    = w_sel ? req1_b : req0_b;
    assign w_rsp_fire = r_gnt ? rsp1_ready : rsp0_ready;

    assign req0_ready = w_accept && !w_sel;
    assign req1_ready = w_accept &&  w_sel;

    assign mul_start  = r_mul_start;
    assign mul_abort  = r_mul_abort;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;

    // Only the owning channel sees the result; the idle channel stays at zero.
    assign rsp0_valid = r_rsp_valid[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp0_data  = {PW{r_rsp_valid[0]}} & r_res_q;
    assign rsp1_data  = {PW{r_rsp_valid[1]}} & r_res_q;
    assign rsp0_err   = r_rsp_valid[0] & r_err_q;
    assign rsp1_err   = r_rsp_valid[1] & r_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 1'b0;
            r_last_gnt  <= 1'b1;
            r_timer     <= '0;
            r_res_q     <= '0;
            r_err_q     <= 1'b0;
            r_mul_start <= 1'b0;
            r_mul_abort <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rsp_valid <= '0;
        end else begin
            r_mul_start <= 1'b0;
            r_mul_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mul_a     <= w_sel_a;
                        r_mul_b     <= w_sel_b;
                        r_gnt       <= w_sel;
                        r_mul_start <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_timer <= r_timer + 8'd1;
                    // A done on the last watchdog cycle still counts as success.
                    if (mul_done) begin
                        r_res_q     <= mul_result;
                        r_err_q     <= 1'b0;
                        r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
                        r_state     <= ST_RESP;
                    end else if (r_timer == TMO_LAST) begin
                        r_res_q     <= '0;
                        r_err_q     <= 1'b1;
                        r_mul_abort <= 1'b1;
                        r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_fire) begin
                        r_last_gnt  <= r_gnt;
                        r_rsp_valid <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: vector table, directed corner sequences, and a
// randomized run scored against per-requester operation queues.
module tb_mul_share_arbiter;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned TIMEOUT = 64;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    typedef struct packed {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  lat;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rq_valid;
    logic [15:0] rq_a [2];
    logic [15:0] rq_b [2];
    wire  [1:0]  rq_ready;
    wire  [1:0]  rs_valid;
    logic [1:0]  rs_ready;
    wire  [31:0] rs_data [2];
    wire  [1:0]  rs_err;
    wire         mul_start;
    wire         mul_abort;
    wire  [15:0] mul_a;
    wire  [15:0] mul_b;
    logic        mul_done;
    logic [31:0] mul_result;

    mul_share_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (rq_valid[0]),
        .req0_a     (rq_a[0]),
        .req0_b     (rq_b[0]),
        .req0_ready (rq_ready[0]),
        .rsp0_valid (rs_valid[0]),
        .rsp0_ready (rs_ready[0]),
        .rsp0_data  (rs_data[0]),
        .rsp0_err   (rs_err[0]),
        .req1_valid (rq_valid[1]),
        .req1_a     (rq_a[1]),
        .req1_b     (rq_b[1]),
        .req1_ready (rq_ready[1]),
        .rsp1_valid (rs_valid[1]),
        .rsp1_ready (rs_ready[1]),
        .rsp1_data  (rs_data[1]),
        .rsp1_err   (rs_err[1]),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .mul_abort  (mul_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    op_t         ops_q [2][$];
    op_t         exp_q [2][$];
    int          lat_q[$];
    int          lat_used_q[$];
    int          grant_log[$];
    bit          hold [2];
    int          mode_rdy [2];
    bit          gaps;
    bit          late_done;
    int          mul_cnt;
    logic [31:0] mul_prod;
    bit          prev_start;
    logic [1:0]  prev_valid;
    int          cyc, start_cyc, n_starts, n_accepts;
    int          acc_cyc [2];
    int          rise_cyc [2];
    int          last_owner;
    logic [31:0] last_data;
    logic        last_err;
    int          last_id;
    int          total, bad;
    vec_t        vt [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // An operation whose done never arrives inside the watchdog window is an error.
    function automatic bit is_hang(input int l);
        return (l == 0) || (l > int'(TIMEOUT));
    endfunction

    task automatic add_op(input int n, input logic [15:0] a, input logic [15:0] b);
        op_t o;
        o.a = a;
        o.b = b;
        ops_q[n].push_back(o);
    endtask

    // One clock: multiplier model, requester drive, then checks on settled outputs.
    task automatic tick();
        int  l;
        bit  h;
        op_t o;
        @(posedge clk);
        #1;
        cyc++;
        mul_done   = 1'b0;
        mul_result = 32'($urandom);
        if (mul_cnt > 0) begin
            mul_cnt--;
            if (mul_cnt == 0) begin
                mul_done   = 1'b1;
                mul_result = mul_prod;
            end
        end
        if (late_done) begin
            mul_done   = 1'b1;
            mul_result = 32'hDEADBEEF;
            late_done  = 1'b0;
        end
        if (mul_start) begin
            chk("start_single_cycle", 64'(prev_start), 64'(0));
            l = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
            lat_used_q.push_back(l);
            mul_prod  = 32'(mul_a) * 32'(mul_b);
            mul_cnt   = l;
            start_cyc = cyc;
            n_starts++;
        end
        prev_start = mul_start;
        if (mul_abort) begin
            chk("abort_only_on_timeout", 64'((lat_used_q.size() > 0) && is_hang(lat_used_q[0])), 64'(1));
            chk("abort_wait_cycles", 64'(cyc - start_cyc - 1), 64'(TIMEOUT));
        end
        for (int n = 0; n < 2; n++) begin
            if (!hold[n] && ops_q[n].size() > 0 && (!gaps || $urandom_range(0, 2) != 0))
                hold[n] = 1'b1;
            rq_valid[n] = hold[n];
            if (hold[n]) begin
                rq_a[n] = ops_q[n][0].a;
                rq_b[n] = ops_q[n][0].b;
            end else begin
                rq_a[n] = 16'($urandom);
                rq_b[n] = 16'($urandom);
            end
            rs_ready[n] = (mode_rdy[n] == 0) ? 1'b1 :
                          (mode_rdy[n] == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
        #1;
        chk("ready_only_if_valid", 64'(rq_ready & ~rq_valid), 64'(0));
        chk("ready_onehot", 64'(rq_ready == 2'b11), 64'(0));
        for (int n = 0; n < 2; n++) begin
            if (rq_valid[n] && rq_ready[n]) begin
                if (rq_valid == 2'b11) chk("rr_winner", 64'(n), 64'(1 - last_owner));
                o = ops_q[n].pop_front();
                exp_q[n].push_back(o);
                hold[n]    = 1'b0;
                acc_cyc[n] = cyc;
                grant_log.push_back(n);
                n_accepts++;
            end
        end
        for (int n = 0; n < 2; n++) begin
            if (rs_valid[n])
                chk("other_rsp_quiet", 64'({rs_valid[1-n], rs_err[1-n], rs_data[1-n]}), 64'(0));
            if (rs_valid[n] && !prev_valid[n]) begin
                rise_cyc[n] = cyc;
                chk("rsp_expected", 64'(exp_q[n].size() > 0 && lat_used_q.size() > 0), 64'(1));
            end
            if (rs_valid[n] && rs_ready[n] && exp_q[n].size() > 0 && lat_used_q.size() > 0) begin
                o = exp_q[n].pop_front();
                l = lat_used_q.pop_front();
                h = is_hang(l);
                chk("rsp_data", 64'(rs_data[n]), 64'(h ? 32'h0 : 32'(o.a) * 32'(o.b)));
                chk("rsp_err", 64'(rs_err[n]), 64'(h));
                chk("rsp_latency", 64'(rise_cyc[n] - acc_cyc[n]), 64'(h ? int'(TIMEOUT) + 2 : l + 2));
                last_owner = n;
                last_data  = rs_data[n];
                last_err   = rs_err[n];
                last_id    = n;
            end
        end
        prev_valid = rs_valid;
    endtask

    // The multiplier model keeps counting through reset, like a real core would.
    task automatic do_reset();
        for (int n = 0; n < 2; n++) begin
            ops_q[n].delete();
            exp_q[n].delete();
            hold[n]     = 1'b0;
            mode_rdy[n] = 0;
        end
        lat_q.delete();
        lat_used_q.delete();
        late_done  = 1'b0;
        prev_start = 1'b0;
        prev_valid = '0;
        last_owner = 1;
        gaps       = 1'b0;
        rst_n      = 1'b0;
        tick();
        chk("reset_flags", 64'({rs_valid, rs_err, rq_ready, mul_start, mul_abort}), 64'(0));
        chk("reset_rsp_data", 64'({rs_data[0], rs_data[1]}), 64'(0));
        chk("reset_mul_ops", 64'({mul_a, mul_b}), 64'(0));
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget, input string nm);
        int k;
        int pending;
        k = 0;
        pending = ops_q[0].size() + ops_q[1].size() + exp_q[0].size() + exp_q[1].size();
        while (pending > 0 && k < budget) begin
            tick();
            k++;
            pending = ops_q[0].size() + ops_q[1].size() + exp_q[0].size() + exp_q[1].size();
        end
        chk({nm, "_drained"}, 64'(pending), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int k, gl0, s0, a0, r;
        rst_n = 1'b0; rq_valid = '0; rs_ready = '0;
        rq_a[0] = '0; rq_a[1] = '0; rq_b[0] = '0; rq_b[1] = '0;
        mul_done = 1'b0; mul_result = '0; mul_cnt = 0; mul_prod = '0;
        total = 0; bad = 0; cyc = 0; start_cyc = 0; n_starts = 0; n_accepts = 0;
        last_data = '0; last_err = 1'b0; last_id = 0;

        vt[0] = '{1'b0, 16'h0003, 16'h0005, 8'd3,  32'h0000000F, 1'b0};
        vt[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 8'd1,  32'hFFFE0001, 1'b0};
        vt[2] = '{1'b0, 16'h0000, 16'h1234, 8'd2,  32'h00000000, 1'b0};
        vt[3] = '{1'b1, 16'h8000, 16'h0002, 8'd64, 32'h00010000, 1'b0};
        vt[4] = '{1'b0, 16'h1234, 16'h5678, 8'd0,  32'h00000000, 1'b1};
        vt[5] = '{1'b1, 16'h00FF, 16'h0100, 8'd65, 32'h00000000, 1'b1};
        vt[6] = '{1'b1, 16'h0007, 16'h0009, 8'd5,  32'h0000003F, 1'b0};

        do_reset();

        for (int i = 0; i < 7; i++) begin
            s0 = n_starts;
            a0 = n_accepts;
            lat_q.push_back(int'(vt[i].lat));
            add_op(int'(vt[i].id), vt[i].a, vt[i].b);
            drain(200, "vec");
            chk("vec_data", 64'(last_data), 64'(vt[i].exp_data));
            chk("vec_err", 64'(last_err), 64'(vt[i].exp_err));
            chk("vec_owner", 64'(last_id), 64'(vt[i].id));
            chk("vec_one_start", 64'(n_starts - s0), 64'(1));
            chk("vec_one_accept", 64'(n_accepts - a0), 64'(1));
            if (vt[i].exp_err) begin
                late_done = 1'b1;
                repeat (4) begin
                    tick();
                    chk("late_done_ignored", 64'(rs_valid), 64'(0));
                end
            end
        end

        // Both requesters busy from reset: strict alternation starting with 0.
        do_reset();
        gl0 = grant_log.size();
        for (int j = 0; j < 3; j++) begin
            add_op(0, 16'($urandom), 16'($urandom));
            add_op(1, 16'($urandom), 16'($urandom));
        end
        repeat (6) lat_q.push_back($urandom_range(1, 4));
        drain(200, "rr");
        for (int j = 0; j < 6; j++)
            chk("rr_order", 64'(grant_log[gl0 + j]), 64'(j % 2));

        // Response back-pressure must freeze the channel and block new grants.
        mode_rdy[0] = 2;
        lat_q.push_back(2);
        lat_q.push_back(1);
        add_op(0, 16'h0011, 16'h0013);
        k = 0;
        while (!rs_valid[0] && k < 50) begin tick(); k++; end
        chk("hold_rsp_seen", 64'(rs_valid[0]), 64'(1));
        add_op(1, 16'h0102, 16'h0003);
        repeat (10) begin
            tick();
            chk("hold_valid", 64'(rs_valid[0]), 64'(1));
            chk("hold_data", 64'(rs_data[0]), 64'(32'h00000143));
            chk("hold_no_accept1", 64'(rq_ready[1]), 64'(0));
        end
        gl0 = grant_log.size();
        mode_rdy[0] = 0;
        drain(100, "hold");
        chk("hold_then_req1", 64'(grant_log.size() == gl0 + 1 && grant_log[gl0] == 1), 64'(1));

        // Reset in the middle of WAIT; the dropped operation's done lands in IDLE.
        lat_q.push_back(8);
        add_op(0, 16'h00AA, 16'h0055);
        k = 0;
        while (!mul_start && k < 20) begin tick(); k++; end
        chk("mw_started", 64'(mul_start), 64'(1));
        repeat (5) tick();
        do_reset();
        repeat (8) begin
            tick();
            chk("mw_no_rsp", 64'(rs_valid), 64'(0));
        end
        gl0 = grant_log.size();
        add_op(0, 16'h0004, 16'h0004);
        add_op(1, 16'h0006, 16'h0006);
        lat_q.push_back(2);
        lat_q.push_back(3);
        drain(100, "post_reset");
        chk("post_reset_first0", 64'(grant_log[gl0]), 64'(0));

        // Randomized traffic with idle gaps, random back-pressure and timeouts.
        gaps = 1'b1;
        mode_rdy[0] = 1;
        mode_rdy[1] = 1;
        for (int j = 0; j < 60; j++) begin
            r = $urandom_range(0, 19);
            lat_q.push_back(r < 2 ? 0 : r == 2 ? 64 : r == 3 ? 65 : int'($urandom_range(1, 6)));
        end
        for (int j = 0; j < 30; j++) begin
            add_op(0, 16'($urandom), 16'($urandom));
            add_op(1, 16'($urandom), 16'($urandom));
        end
        drain(9000, "random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
